// File: rtl/sprite_bus_arbiter.sv
// Sprite memory bus arbiter: one owner at a time, with a float (turnaround) cycle before every access.
// Build option: define SPRITE_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed priority.
module sprite_bus_arbiter #(
    parameter int N_REQ      = 4,
    parameter int ACCESS_CYC = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic [N_REQ-1:0] wr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [N_REQ-1:0] drv_oe_o,
    output logic             mem_oe_o,
    output logic             mem_we_o,
    output logic [N_REQ-1:0] done_o,
    output logic             busy_o
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_TURN   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYC - 1);

    logic [1:0]       state_q, state_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic             wr_q, wr_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             arb;
    logic [IW-1:0]    winner;

    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] drv_oe_q, drv_oe_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             mem_oe_q, mem_oe_d;
    logic             mem_we_q, mem_we_d;
    logic             busy_q, busy_d;
    logic [N_REQ-1:0] owner_oh;
    logic             acc_d;

`ifdef SPRITE_ARB_ROUND_ROBIN_EN
    logic [IW-1:0] ptr_q, ptr_d;

    function automatic logic [IW-1:0] pick_rr(input logic [N_REQ-1:0] r, input logic [IW-1:0] p);
        logic [IW-1:0] w;
        logic          found;
        int            idx;
        w     = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(p) + i) % N_REQ;
            if (!found && r[idx]) begin
                w     = IW'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign winner = pick_rr(req_i, ptr_q);

    always_comb begin
        ptr_d = ptr_q;
        if (arb) begin
            ptr_d = (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    function automatic logic [IW-1:0] pick_fixed(input logic [N_REQ-1:0] r);
        logic [IW-1:0] w;
        w = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (r[i]) begin
                w = IW'(i);
            end
        end
        return w;
    endfunction

    assign winner = pick_fixed(req_i);
`endif

    // Arbitration happens from IDLE or on the last ACCESS cycle; the owner's req is otherwise ignored.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        arb     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|req_i) begin
                    arb = 1'b1;
                end
            end
            S_TURN: begin
                state_d = S_ACCESS;
                cnt_d   = CNT_LOAD;
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (|req_i) begin
                        arb = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (arb) begin
            state_d = S_TURN;
            owner_d = winner;
            wr_d    = wr_i[winner];
        end
    end

    // Outputs are derived from the next state so they can be registered without adding latency.
    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_d] = 1'b1;
        acc_d             = (state_d == S_ACCESS);
        busy_d            = (state_d != S_IDLE);
        grant_d           = busy_d ? owner_oh : '0;
        drv_oe_d          = (acc_d && wr_d) ? owner_oh : '0;
        mem_we_d          = acc_d && wr_d;
        mem_oe_d          = acc_d && !wr_d;
        done_d            = (acc_d && (cnt_d == 4'd0)) ? owner_oh : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            owner_q  <= '0;
            wr_q     <= 1'b0;
            cnt_q    <= 4'd0;
            grant_q  <= '0;
            drv_oe_q <= '0;
            done_q   <= '0;
            mem_oe_q <= 1'b0;
            mem_we_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            wr_q     <= wr_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            drv_oe_q <= drv_oe_d;
            done_q   <= done_d;
            mem_oe_q <= mem_oe_d;
            mem_we_q <= mem_we_d;
            busy_q   <= busy_d;
        end
    end

    assign grant_o  = grant_q;
    assign drv_oe_o = drv_oe_q;
    assign done_o   = done_q;
    assign mem_oe_o = mem_oe_q;
    assign mem_we_o = mem_we_q;
    assign busy_o   = busy_q;

endmodule
